// File: rtl/fp_accum_scheduler.sv
// Round-robin scheduler sharing one fp16->fp32 widen + fp32 adder between NumReq
// private accumulators; a last element pushes the finished sum to one output register.
module fp_accum_scheduler #(
  parameter int NumReq  = 4,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [NumReq-1:0]    req_valid_i,
  input  logic [NumReq*16-1:0] req_data_i,
  input  logic [NumReq-1:0]    req_last_i,
  output logic [NumReq-1:0]    req_ready_o,
  output logic                 result_valid_o,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [31:0]          result_data_o,
  input  logic                 result_ready_i,
  output logic                 busy_o
);

  function automatic logic [31:0] fp16_to_fp32(input logic [15:0] h);
    logic [31:0] r;
    logic [10:0] mm;
    logic [7:0]  e;
    mm = {1'b0, h[9:0]};
    e  = 8'd113;
    if (h[14:10] == 5'h1f) begin
      r = {h[15], 8'hff, h[9:0], 13'd0};
    end else if (h[14:10] != 5'd0) begin
      r = {h[15], {3'd0, h[14:10]} + 8'd112, h[9:0], 13'd0};
    end else if (h[9:0] != 10'd0) begin
      // subnormal fp16 is always a normal fp32: slide the leading one up
      for (int i = 0; i < 10; i++) begin
        if (!mm[10]) begin
          mm = mm << 1;
          e  = e - 8'd1;
        end else begin
          mm = mm;
        end
      end
      r = {h[15], e, mm[9:0], 13'd0};
    end else begin
      r = {h[15], 31'd0};
    end
    return r;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic        a_nan, b_nan, a_inf, b_inf, sub, rup;
    logic [7:0]  ex, ey, d;
    logic [26:0] xe, ye, n;
    logic [53:0] wide;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] mr;
    a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    r = 32'h7fc00000;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      r = 32'h7fc00000;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      xe = {(x[30:23] != 8'd0), x[22:0], 3'd0};
      ye = {(y[30:23] != 8'd0), y[22:0], 3'd0};
      d  = ex - ey;
      // align the smaller operand, folding shifted-out bits into sticky
      if (d >= 8'd27) begin
        ye = {26'd0, |y[30:0]};
      end else begin
        wide  = {ye, 27'd0} >> d;
        ye    = wide[53:27];
        ye[0] = ye[0] | (|wide[26:0]);
      end
      sub = x[31] ^ y[31];
      s   = sub ? ({1'b0, xe} - {1'b0, ye}) : ({1'b0, xe} + {1'b0, ye});
      e   = {2'd0, ex};
      if (s == 28'd0) begin
        r = {x[31] & y[31], 31'd0};
      end else begin
        if (s[27]) begin
          n    = s[27:1];
          n[0] = n[0] | s[0];
          e    = e + 10'd1;
        end else begin
          n = s[26:0];
          for (int i = 0; i < 26; i++) begin
            if (!n[26] && (e > 10'd1)) begin
              n = n << 1;
              e = e - 10'd1;
            end else begin
              n = n;
            end
          end
        end
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'd0, rup};
        if (mr[24]) begin
          mr = mr >> 1;
          e  = e + 10'd1;
        end else begin
          mr = mr;
        end
        if (e >= 10'd255) begin
          r = {x[31], 8'hff, 23'd0};
        end else begin
          r = {x[31], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
        end
      end
    end
    return r;
  endfunction

  logic [31:0]        acc_r [NumReq];
  logic [NumReq-1:0]  armed_r;
  logic [IdWidth-1:0] ptr_r;

  logic               out_free_s;
  logic [NumReq-1:0]  elig_s;
  logic               gnt_valid_s;
  logic [IdWidth-1:0] gnt_id_s;
  logic [15:0]        gnt_data_s;
  logic               gnt_last_s;
  logic [31:0]        sum_s;
  int                 idx_s;
  logic               hit_s;

  // Eligibility: last elements additionally need room in the output register
  always_comb begin
    out_free_s = !result_valid_o | result_ready_i;
    elig_s     = (req_valid_i & ~req_last_i) | (req_valid_i & req_last_i & {NumReq{out_free_s}});
    elig_s     = elig_s & {NumReq{!clear_i && !rst_i}};
  end

  // Round-robin pick: first eligible index starting at the pointer
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = {IdWidth{1'b0}};
    idx_s       = 0;
    hit_s       = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      idx_s       = (int'(ptr_r) + i) % NumReq;
      hit_s       = !gnt_valid_s && elig_s[idx_s];
      gnt_id_s    = hit_s ? IdWidth'(idx_s) : gnt_id_s;
      gnt_valid_s = gnt_valid_s | hit_s;
    end
  end

  // Shared datapath for the granted requester
  always_comb begin
    req_ready_o = {NumReq{gnt_valid_s}} & ({{(NumReq-1){1'b0}}, 1'b1} << gnt_id_s);
    gnt_data_s  = req_data_i[gnt_id_s*16 +: 16];
    gnt_last_s  = req_last_i[gnt_id_s];
    sum_s       = fp_add(fp16_to_fp32(gnt_data_s), acc_r[gnt_id_s]);
  end

  assign busy_o = (|armed_r) | result_valid_o;

  // Accumulators, output register and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumReq; k++) acc_r[k] <= 32'd0;
      armed_r        <= {NumReq{1'b0}};
      ptr_r          <= {IdWidth{1'b0}};
      result_valid_o <= 1'b0;
      result_id_o    <= {IdWidth{1'b0}};
      result_data_o  <= 32'd0;
    end else if (clear_i) begin
      for (int k = 0; k < NumReq; k++) acc_r[k] <= 32'd0;
      armed_r        <= {NumReq{1'b0}};
      result_valid_o <= 1'b0;
    end else begin
      if (result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
      end else begin
        result_valid_o <= result_valid_o;
      end
      // a new last-grant load overrides the handshake clear above
      if (gnt_valid_s) begin
        if (gnt_last_s) begin
          result_valid_o    <= 1'b1;
          result_id_o       <= gnt_id_s;
          result_data_o     <= sum_s;
          acc_r[gnt_id_s]   <= 32'd0;
          armed_r[gnt_id_s] <= 1'b0;
        end else begin
          acc_r[gnt_id_s]   <= sum_s;
          armed_r[gnt_id_s] <= 1'b1;
        end
        ptr_r <= (gnt_id_s == IdWidth'(NumReq - 1)) ? {IdWidth{1'b0}} : gnt_id_s + {{(IdWidth-1){1'b0}}, 1'b1};
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_fp_accum_scheduler.sv
// Self-checking bench for fp_accum_scheduler: directed scenarios plus a randomized
// run against a real-arithmetic reference model (operands chosen so sums are exact).
module tb_fp_accum_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, clear, result_ready;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*16-1:0] req_data;
  logic          result_valid, busy;
  logic [1:0]    result_id;
  logic [31:0]   result_data;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  fp_accum_scheduler #(.NumReq(N)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .result_valid_o(result_valid), .result_id_o(result_id),
    .result_data_o(result_data), .result_ready_i(result_ready), .busy_o(busy)
  );

  // value n/4 encoded as fp16 (n nonzero, small)
  function automatic logic [15:0] fp16_of(input int n);
    logic [63:0] b;
    b = $realtobits(n / 4.0);
    return {b[63], 5'(b[62:52] - 11'd1008), b[51:42]};
  endfunction

  // exactly representable real to fp32 bits
  function automatic logic [31:0] fp32_of(input real v);
    logic [63:0] b;
    if (v == 0.0) return 32'd0;
    b = $realtobits(v);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; req_valid = '0; req_last = '0; req_data = '0; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; result_ready = 1'b1;
    req_valid = 4'b1111; req_last = 4'b0101; req_data = {4{16'h3c00}};
    settle();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tick(); tick();
    n_checks++;
    if ({result_valid, result_id, result_data, busy} !== 36'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b id=%0d d=%h busy=%b expected all 0", result_valid, result_id, result_data, busy);
    end
    rst = 1'b0; req_valid = '0; req_last = '0;
  endtask

  task automatic test_single_sum();
    do_reset();
    result_ready = 1'b1;
    req_valid = 4'b0001; req_data[15:0] = 16'h3c00;
    settle();
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    n_checks++;
    if ({result_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL single_mid: got v=%b busy=%b expected v=0 busy=1", result_valid, busy); end
    tick();
    req_data[15:0] = 16'h3800; req_last = 4'b0001;
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data} !== {1'b1, 2'd0, 32'h40200000}) begin
      n_fail++; $display("FAIL single_result: got v=%b id=%0d d=%h expected v=1 id=0 d=40200000", result_valid, result_id, result_data);
    end
    req_valid = '0; req_last = '0;
    tick();
    n_checks++;
    if ({result_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got v=%b busy=%b expected 0 0", result_valid, busy); end
    req_valid = 4'b0001; req_last = 4'b0001; req_data[15:0] = 16'h3c00;
    tick();
    n_checks++;
    if (result_data !== 32'h3f800000) begin n_fail++; $display("FAIL single_rearm: got %h expected 3f800000", result_data); end
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; req_data = {4{16'h3c00}};
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (req_ready !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_all[%0d]: got %b expected %b", i, req_ready, 4'(1 << (i % 4))); end
      tick();
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if (req_ready !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_fail++; $display("FAIL rr_odd[%0d]: got %b expected %b", i, req_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0100; req_data[47:32] = 16'h4000;
    tick();
    req_valid = 4'b0011; req_last = 4'b0001; req_data[15:0] = 16'h3c00; req_data[31:16] = 16'h3c00;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b expected 0010", i, req_ready); end
      n_checks++;
      if ({result_valid, result_id, result_data} !== {1'b1, 2'd2, 32'h40000000}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=2 d=40000000", i, result_valid, result_id, result_data);
      end
      tick();
    end
    result_ready = 1'b1;
    settle();
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release: got %b expected 0001", req_ready); end
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data} !== {1'b1, 2'd0, 32'h3f800000}) begin
      n_fail++; $display("FAIL bp_result: got v=%b id=%0d d=%h expected v=1 id=0 d=3f800000", result_valid, result_id, result_data);
    end
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    result_ready = 1'b1;
    req_valid = 4'b0011; req_last = 4'b0011; req_data[15:0] = 16'h3c00; req_data[31:16] = 16'h3800;
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data} !== {1'b1, 2'd0, 32'h3f800000}) begin
      n_fail++; $display("FAIL b2b_first: got v=%b id=%0d d=%h expected v=1 id=0 d=3f800000", result_valid, result_id, result_data);
    end
    req_valid = 4'b0010; req_last = 4'b0010;
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data} !== {1'b1, 2'd1, 32'h3f000000}) begin
      n_fail++; $display("FAIL b2b_second: got v=%b id=%0d d=%h expected v=1 id=1 d=3f000000", result_valid, result_id, result_data);
    end
    req_valid = '0; req_last = '0;
    tick();
    n_checks++;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", result_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    req_valid = 4'b0010; req_data[31:16] = 16'h3e00;
    tick();
    req_valid = 4'b0100; req_last = 4'b0100; req_data[47:32] = 16'h4000;
    tick();
    n_checks++;
    if ({result_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL clr_setup: got v=%b busy=%b expected 1 1", result_valid, busy); end
    clear = 1'b1; result_ready = 1'b1; req_valid = 4'b1111; req_last = 4'b0000;
    settle();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL clr_nogrant: got %b expected 0000", req_ready); end
    tick();
    n_checks++;
    if ({result_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL clr_after: got v=%b busy=%b expected 0 0", result_valid, busy); end
    clear = 1'b0; req_valid = 4'b0010; req_last = 4'b0010; req_data[31:16] = 16'h3c00;
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data} !== {1'b1, 2'd1, 32'h3f800000}) begin
      n_fail++; $display("FAIL clr_fresh: got v=%b id=%0d d=%h expected v=1 id=1 d=3f800000", result_valid, result_id, result_data);
    end
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1000; req_data[63:48] = 16'h4400;
    tick();
    req_valid = 4'b0001; req_last = 4'b0000; req_data[15:0] = 16'h3c00;
    tick();
    rst = 1'b1; req_valid = 4'b1111; req_last = 4'b0110;
    settle();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
    tick();
    n_checks++;
    if ({result_valid, result_id, result_data, busy} !== 36'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b id=%0d d=%h busy=%b expected all 0", result_valid, result_id, result_data, busy);
    end
    rst = 1'b0; req_valid = 4'b1010; req_last = 4'b0000;
    settle();
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first: got %b expected 0010", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    real  macc [N];
    bit   marmed [N];
    int   vals [N];
    int   mptr, g, k;
    logic mrv;
    logic [1:0]  mid;
    logic [31:0] mdata;
    logic [3:0]  exp_ready;
    do_reset();
    for (int j = 0; j < N; j++) begin macc[j] = 0.0; marmed[j] = 1'b0; end
    mptr = 0; mrv = 1'b0; mid = 2'd0; mdata = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear = ($urandom_range(0, 39) == 0);
      result_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) begin
        vals[j] = int'($urandom_range(0, 40)) - 20;
        if (vals[j] == 0) vals[j] = 3;
        req_data[16*j +: 16] = fp16_of(vals[j]);
        req_valid[j] = ($urandom_range(0, 2) != 0);
        req_last[j]  = ($urandom_range(0, 3) == 0);
      end
      settle();
      g = -1;
      for (int i = 0; i < N; i++) begin
        k = (mptr + i) % N;
        if (g < 0 && req_valid[k] && !clear && (!req_last[k] || !mrv || result_ready)) g = k;
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b", cyc, req_ready, exp_ready); end
      if (clear) begin
        for (int j = 0; j < N; j++) begin macc[j] = 0.0; marmed[j] = 1'b0; end
        mrv = 1'b0;
      end else begin
        if (mrv && result_ready) mrv = 1'b0;
        if (g >= 0) begin
          macc[g] = macc[g] + vals[g] / 4.0;
          if (req_last[g]) begin
            mrv = 1'b1; mid = 2'(g); mdata = fp32_of(macc[g]);
            macc[g] = 0.0; marmed[g] = 1'b0;
          end else begin
            marmed[g] = 1'b1;
          end
          mptr = (g + 1) % N;
        end
      end
      tick();
      n_checks++;
      if (result_valid !== mrv || (mrv && (result_id !== mid || result_data !== mdata))) begin
        n_fail++; $display("FAIL rand_result[%0d]: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h", cyc, result_valid, result_id, result_data, mrv, mid, mdata);
      end
      n_checks++;
      if (busy !== (marmed[0] | marmed[1] | marmed[2] | marmed[3] | mrv)) begin
        n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", cyc, busy, marmed[0] | marmed[1] | marmed[2] | marmed[3] | mrv);
      end
    end
    clear = 1'b0; req_valid = '0; req_last = '0;
  endtask

  initial begin
    test_reset();
    test_single_sum();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
